uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler sharing one UART transmit path (frame generator + PISO serializer) among `NUM_REQ` byte sources. It arbitrates pending requests, latches the winner's byte and frame configuration, drives `send` into the PISO and tracks `tx_active`/`tx_done` to completion. It also enforces an inter-frame gap and a watchdog timeout. It sits between client logic and the PISO's `send`/`parity_type`/`stop_bits`/`data_length` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8
- `GAP_CYCLES`, 2: idle clocks inserted after each frame, 0..255
- `TIMEOUT_CYCLES`, 4096: maximum clocks from `send` assertion to `tx_done`
- `clock` in 1: system clock, single clock domain
- `rst` in 1: synchronous, active-high reset
- `req_valid` in NUM_REQ: per-requester pending flag
- `req_data` in 8*NUM_REQ: byte per requester, requester i at [8i+7:8i]
- `req_parity_type` in 2*NUM_REQ: 00/11 none, 01 odd, 10 even
- `req_stop_bits` in NUM_REQ: 0 = one stop bit, 1 = two
- `req_data_length` in NUM_REQ: 0 = 7 data bits, 1 = 8
- `req_ack` out NUM_REQ: one-hot, single-cycle acceptance pulse
- `req_done` out NUM_REQ: one-hot, single-cycle successful-completion pulse
- `tx_data` out 8: latched byte; bit 7 forced to 0 when `data_length`=0
- `parity_type` out 2, `stop_bits` out 1, `data_length` out 1: latched configuration to the PISO
- `send` out 1: transmit request to the PISO
- `tx_active` in 1, `tx_done` in 1: PISO status, synchronous to `clock`
- `grant_id` out $clog2(NUM_REQ): index of the current owner
- `busy` out 1: high in every state except IDLE
- `timeout_err` out 1: single-cycle pulse on watchdog expiry

## Operation
- States: IDLE, LOAD, WAIT_ACTIVE, WAIT_DONE, GAP.
- IDLE: if any `req_valid`, select the first set bit searching from `last_grant+1` modulo NUM_REQ. Capture its fields and `grant_id`, then go to LOAD.
- LOAD: `req_ack[grant_id]`=1 for this cycle only. Go to WAIT_ACTIVE.
- WAIT_ACTIVE: `send`=1. On `tx_active`=1 go to WAIT_DONE. On `tx_done`=1 (without `tx_active`), complete exactly as in WAIT_DONE.
- WAIT_DONE: `send`=1. On `tx_done`=1, pulse `req_done[grant_id]` and update `last_grant`=`grant_id`, then go to GAP.
- Watchdog: counter cleared on LOAD exit and incremented each cycle in WAIT_ACTIVE and WAIT_DONE. When it reaches `TIMEOUT_CYCLES`:
  - `timeout_err` pulses;
  - no `req_done` is issued;
  - `last_grant` is still updated;
  - state goes to GAP.
- GAP: `send`=0 for `GAP_CYCLES` clocks, then IDLE. With `GAP_CYCLES`=0, go from completion directly to IDLE.
- Configuration outputs and `tx_data` stay stable from LOAD until the next capture. They do not change in GAP or IDLE.
- Requesters hold `req_valid` and fields until `req_ack`. Deasserting before acknowledgement withdraws the request; only the IDLE sample matters.

## Timing
- Reset (sync): state IDLE; all outputs 0 (`tx_data` 0, `parity_type` 00, `stop_bits` 0, `data_length` 0, `grant_id` 0); `last_grant`=NUM_REQ-1, so requester 0 has first priority; watchdog 0.
- Request sampled in IDLE at edge N: LOAD (`req_ack`) at N+1, `send` high from N+2.
- `tx_done` sampled at edge M: at M+1 `send`=0 and `req_done` pulses. IDLE is reached at M+1+`GAP_CYCLES`.
- Minimum throughput: one frame per 4+`GAP_CYCLES` clocks plus PISO time.
- `tx_done` and watchdog expiry in the same cycle: completion wins; no `timeout_err`.
- `rst` mid-frame: `send` drops at the next edge, and no `req_done` or `timeout_err` is issued.
- New requests arriving in LOAD, WAIT_*, or GAP are ignored until IDLE.

## Structure
- Shared package/header `uart_pkg`: parity encodings (NONE, ODD, EVEN), stop/length encodings, state encodings.
- Sub-module `rr_arbiter`: combinational round-robin select with inputs `req`/`last_grant` and outputs `grant_onehot`/`grant_id`. Instantiated once; the FSM and watchdog live in `uart_tx_scheduler`.

## Test plan
- Single request: requester 2 sends 0xA5 with 8-bit, even parity, one stop bit.
  - Expect `req_ack`=0100 one cycle after sampling and `send` the next cycle.
  - Model asserts `tx_active`, then `tx_done` after 20 clocks; expect `req_done`=0100 one cycle later and IDLE after 2 gap clocks.
- All four requesters valid continuously: grants occur in order 0,1,2,3,0; each `req_ack` is exactly one cycle and no requester is starved.
- 7-bit length with `req_data`=0xFF: `tx_data`=0x7F, `data_length`=0, `stop_bits`=1 held through the frame.
- PISO model never responds, with `TIMEOUT_CYCLES`=16: `timeout_err` pulses 16 clocks after `send` rises and `send` drops; no `req_done`; the next requester wins on re-arbitration.
- `rst` asserted in WAIT_DONE: all outputs 0 at the next edge, then requester 0 has priority.
- `tx_done` on the same cycle as watchdog expiry: `req_done` pulses and `timeout_err` stays 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit scheduler: frame configuration codes,
// scheduler states and the data-length masking helper.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_ODD  = 2'b01;
  localparam logic [1:0] PARITY_EVEN = 2'b10;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  localparam logic LEN_7 = 1'b0;
  localparam logic LEN_8 = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_LOAD        = 3'd1,
    ST_WAIT_ACTIVE = 3'd2,
    ST_WAIT_DONE   = 3'd3,
    ST_GAP         = 3'd4
  } state_t;

  // A 7-bit frame never carries bit 7, so it is cleared at capture time.
  function automatic logic [7:0] mask_data(input logic [7:0] data, input logic len);
    return (len == LEN_7) ? {1'b0, data[6:0]} : data;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first set request strictly after last_grant,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic [NUM_REQ-1:0]         grant_onehot,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);
  localparam int ID_W = $clog2(NUM_REQ);

  int   idx;
  logic found;

  always_comb begin
    grant_onehot = '0;
    grant_id     = '0;
    found        = 1'b0;
    idx          = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last_grant) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_onehot[idx] = 1'b1;
        grant_id          = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin owner of a shared UART PISO: arbitrates byte sources, latches the
// winner's frame, drives send until tx_done, then holds an inter-frame gap.
//
// state        | meaning
// IDLE         | sampling req_valid, capture winner on any request
// LOAD         | req_ack pulse to the winner, watchdog cleared
// WAIT_ACTIVE  | send high, waiting for PISO to start
// WAIT_DONE    | send high, waiting for tx_done
// GAP          | send low for GAP_CYCLES clocks before re-arbitrating
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [2*NUM_REQ-1:0]       req_parity_type,
  input  logic [NUM_REQ-1:0]         req_stop_bits,
  input  logic [NUM_REQ-1:0]         req_data_length,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [7:0]                 tx_data,
  output logic [1:0]                 parity_type,
  output logic                       stop_bits,
  output logic                       data_length,
  output logic                       send,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       timeout_err
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            state, state_next;
  logic [ID_W-1:0]   last_grant, arb_id;
  logic [NUM_REQ-1:0] arb_onehot;
  logic [WD_W-1:0]   wdog;
  logic [7:0]        gap_cnt;
  logic              done_flag;
  logic              capture, complete, expire;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req          (req_valid),
    .last_grant   (last_grant),
    .grant_onehot (arb_onehot),
    .grant_id     (arb_id)
  );

  always_ff @(posedge clock) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    send       = 1'b0;
    capture    = 1'b0;
    complete   = 1'b0;
    expire     = 1'b0;
    req_ack    = '0;
    req_done   = '0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (|arb_onehot) begin
          capture    = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        for (int i = 0; i < NUM_REQ; i++) req_ack[i] = (grant_id == ID_W'(i));
        state_next = ST_WAIT_ACTIVE;
      end
      ST_WAIT_ACTIVE, ST_WAIT_DONE: begin
        send = 1'b1;
        // A real tx_done always beats a watchdog expiry landing on the same edge.
        complete = tx_done;
        expire   = !tx_done && (wdog == WD_W'(TIMEOUT_CYCLES - 1));
        if (complete || expire)
          state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
        else if (state == ST_WAIT_ACTIVE && tx_active)
          state_next = ST_WAIT_DONE;
      end
      ST_GAP: begin
        if (gap_cnt == 8'd0) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
    if (done_flag)
      for (int i = 0; i < NUM_REQ; i++) req_done[i] = (grant_id == ID_W'(i));
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      last_grant  <= ID_W'(NUM_REQ - 1);
      grant_id    <= '0;
      tx_data     <= '0;
      parity_type <= '0;
      stop_bits   <= 1'b0;
      data_length <= 1'b0;
      wdog        <= '0;
      gap_cnt     <= '0;
      done_flag   <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done_flag   <= complete;
      timeout_err <= expire;
      if (capture) begin
        grant_id    <= arb_id;
        tx_data     <= mask_data(req_data[8*int'(arb_id) +: 8], req_data_length[arb_id]);
        parity_type <= req_parity_type[2*int'(arb_id) +: 2];
        stop_bits   <= req_stop_bits[arb_id];
        data_length <= req_data_length[arb_id];
      end
      if (state == ST_LOAD) wdog <= '0;
      else if (send)        wdog <= wdog + WD_W'(1);
      if (complete || expire) begin
        last_grant <= grant_id;
        gap_cnt    <= 8'(GAP_CYCLES - 1);
      end else if (state == ST_GAP && gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: one instance with the default watchdog and
// one with a 16-clock watchdog, sharing the requester side.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  logic        clock;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [7:0]  req_parity_type;
  logic [3:0]  req_stop_bits;
  logic [3:0]  req_data_length;

  logic [3:0] req_ack1, req_done1, req_ack2, req_done2;
  logic [7:0] tx_data1, tx_data2;
  logic [1:0] parity_type1, parity_type2, grant_id1, grant_id2;
  logic       stop_bits1, stop_bits2, data_length1, data_length2;
  logic       send1, send2, busy1, busy2, timeout_err1, timeout_err2;
  logic       tx_active1, tx_done1, tx_active2, tx_done2;

  int checks = 0;
  int failures = 0;

  uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(4096)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_parity_type(req_parity_type), .req_stop_bits(req_stop_bits),
    .req_data_length(req_data_length), .req_ack(req_ack1), .req_done(req_done1),
    .tx_data(tx_data1), .parity_type(parity_type1), .stop_bits(stop_bits1),
    .data_length(data_length1), .send(send1), .tx_active(tx_active1),
    .tx_done(tx_done1), .grant_id(grant_id1), .busy(busy1), .timeout_err(timeout_err1)
  );

  uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16)) dut_to (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_parity_type(req_parity_type), .req_stop_bits(req_stop_bits),
    .req_data_length(req_data_length), .req_ack(req_ack2), .req_done(req_done2),
    .tx_data(tx_data2), .parity_type(parity_type2), .stop_bits(stop_bits2),
    .data_length(data_length2), .send(send2), .tx_active(tx_active2),
    .tx_done(tx_done2), .grant_id(grant_id2), .busy(busy2), .timeout_err(timeout_err2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack1();
    int n = 0;
    while (req_ack1 == 4'b0000 && n < 20) begin tick(); n++; end
  endtask

  task automatic wait_ack2();
    int n = 0;
    while (req_ack2 == 4'b0000 && n < 20) begin tick(); n++; end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_data = '0; req_parity_type = '0;
    req_stop_bits = '0; req_data_length = '0;
    tx_active1 = 1'b0; tx_done1 = 1'b0; tx_active2 = 1'b0; tx_done2 = 1'b0;
    tick(); tick();

    // reset state
    check("rst_send", send1, 0);
    check("rst_busy", busy1, 0);
    check("rst_ack", req_ack1, 0);
    check("rst_done", req_done1, 0);
    check("rst_data", tx_data1, 0);
    check("rst_gid", grant_id1, 0);
    check("rst_cfg", {parity_type1, stop_bits1, data_length1}, 0);
    check("rst_to", timeout_err1, 0);

    // single request: requester 2, 0xA5, 8-bit, even parity, one stop
    rst = 1'b0;
    req_valid = 4'b0100;
    req_data = 32'h00A5_0000;
    req_parity_type = {2'b00, PARITY_EVEN, 2'b00, 2'b00};
    req_stop_bits = {4{STOP_ONE}};
    req_data_length = {1'b0, LEN_8, 1'b0, 1'b0};
    tick();
    check("t1_ack", req_ack1, 4'b0100);
    check("t1_gid", grant_id1, 2);
    check("t1_send_load", send1, 0);
    req_valid = 4'b0000;
    tick();
    check("t1_send", send1, 1);
    check("t1_ack_once", req_ack1, 0);
    check("t1_data", tx_data1, 8'hA5);
    check("t1_par", parity_type1, PARITY_EVEN);
    check("t1_len", data_length1, LEN_8);
    check("t1_stop", stop_bits1, STOP_ONE);
    tx_active1 = 1'b1;
    repeat (19) tick();
    check("t1_send_hold", send1, 1);
    tx_active1 = 1'b0;
    tx_done1 = 1'b1;
    tick();
    tx_done1 = 1'b0;
    check("t1_done", req_done1, 4'b0100);
    check("t1_send_drop", send1, 0);
    check("t1_gap_busy", busy1, 1);
    tick();
    check("t1_done_once", req_done1, 0);
    check("t1_gap2_busy", busy1, 1);
    tick();
    check("t1_idle", busy1, 0);
    check("t1_data_idle", tx_data1, 8'hA5);

    // all four continuously valid: 0,1,2,3,0
    rst = 1'b1;
    req_valid = 4'hF;
    req_data = 32'h4433_2211;
    req_parity_type = {4{PARITY_NONE}};
    req_stop_bits = {4{STOP_ONE}};
    req_data_length = {4{LEN_8}};
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_ack1();
      check($sformatf("t2_ack%0d", k), req_ack1, 32'(1) << (k % 4));
      check($sformatf("t2_gid%0d", k), grant_id1, k % 4);
      tick();
      check($sformatf("t2_ack_once%0d", k), req_ack1, 0);
      check($sformatf("t2_data%0d", k), tx_data1, 8'h11 * ((k % 4) + 1));
      tx_active1 = 1'b1;
      tick();
      tx_active1 = 1'b0;
      tx_done1 = 1'b1;
      tick();
      tx_done1 = 1'b0;
      check($sformatf("t2_done%0d", k), req_done1, 32'(1) << (k % 4));
    end

    // 7-bit frame from requester 1 with 0xFF, two stop bits, odd parity
    req_valid = 4'b0010;
    req_data = 32'h0000_FF00;
    req_parity_type = {2'b00, 2'b00, PARITY_ODD, 2'b00};
    req_stop_bits = {1'b0, 1'b0, STOP_TWO, 1'b0};
    req_data_length = {4{LEN_7}};
    wait_ack1();
    check("t3_ack", req_ack1, 4'b0010);
    check("t3_gid", grant_id1, 1);
    req_valid = 4'b0000;
    tick();
    check("t3_data", tx_data1, 8'h7F);
    check("t3_len", data_length1, LEN_7);
    check("t3_stop", stop_bits1, STOP_TWO);
    check("t3_par", parity_type1, PARITY_ODD);
    tx_active1 = 1'b1;
    tick();
    tx_active1 = 1'b0;
    repeat (3) tick();
    check("t3_data_mid", tx_data1, 8'h7F);
    check("t3_stop_mid", stop_bits1, STOP_TWO);
    tx_done1 = 1'b1;
    tick();
    tx_done1 = 1'b0;
    check("t3_done", req_done1, 4'b0010);
    check("t3_data_gap", tx_data1, 8'h7F);
    check("t3_stop_gap", stop_bits1, STOP_TWO);

    // watchdog expiry on the 16-clock instance
    rst = 1'b1;
    req_valid = 4'b0011;
    req_data = 32'h0000_665A;
    req_parity_type = {4{PARITY_NONE}};
    req_stop_bits = {4{STOP_ONE}};
    req_data_length = {1'b0, 1'b0, LEN_8, LEN_8};
    tick();
    rst = 1'b0;
    tick();
    check("t4_ack", req_ack2, 4'b0001);
    check("t4_gid", grant_id2, 0);
    tick();
    check("t4_send", send2, 1);
    check("t4_data", tx_data2, 8'h5A);
    check("t4_cfg", {parity_type2, stop_bits2, data_length2}, {PARITY_NONE, STOP_ONE, LEN_8});
    repeat (15) tick();
    check("t4_send_15", send2, 1);
    check("t4_to_early", timeout_err2, 0);
    tick();
    check("t4_to", timeout_err2, 1);
    check("t4_send_drop", send2, 0);
    check("t4_no_done", req_done2, 0);
    check("t4_gap_busy", busy2, 1);
    tick();
    check("t4_to_once", timeout_err2, 0);
    wait_ack2();
    check("t4_next_ack", req_ack2, 4'b0010);
    check("t4_next_gid", grant_id2, 1);

    // reset while the default instance sits in WAIT_DONE
    tx_active1 = 1'b1;
    tick();
    tx_active1 = 1'b0;
    check("t5_send_pre", send1, 1);
    check("t5_busy_pre", busy1, 1);
    rst = 1'b1;
    tick();
    check("t5_send", send1, 0);
    check("t5_busy", busy1, 0);
    check("t5_data", tx_data1, 0);
    check("t5_cfg", {parity_type1, stop_bits1, data_length1}, 0);
    check("t5_gid", grant_id1, 0);
    check("t5_flags", {req_ack1, req_done1, timeout_err1}, 0);
    rst = 1'b0;
    req_valid = 4'b1001;
    tick();
    check("t5_prio", req_ack1, 4'b0001);
    check("t5_prio2", req_ack2, 4'b0001);

    // tx_done coincides with watchdog expiry on the 16-clock instance
    req_valid = 4'b0000;
    tick();
    check("t6_send", send2, 1);
    repeat (15) tick();
    tx_done2 = 1'b1;
    tick();
    tx_done2 = 1'b0;
    check("t6_done", req_done2, 4'b0001);
    check("t6_no_to", timeout_err2, 0);
    check("t6_send_drop", send2, 0);
    tick();
    check("t6_no_to_after", timeout_err2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
